ldpc_llr_buf: RTL

- Parametrised, double-buffered (ping-pong) LLR input frame buffer placed in front of the LDPC decoder core.
- Accepts a serial soft-LLR stream qualified by sync_in.
- Saturates each sample to the decoder's LLR width and packs PAR samples per memory word.
- Hands complete frames to the decoder through a ready/address/release interface, so the next frame can be received while the current one is being decoded.

---
 rtl/ldpc_llr_buf_pkg.sv | 23 ++
 rtl/ldpc_llr_buf_if.sv | 16 +
 rtl/ldpc_llr_buf_sat.sv | 21 ++
 rtl/ldpc_llr_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_llr_buf_pkg.sv
// Shared constants, write-side state encoding and width helper for the LDPC LLR input buffer.
package ldpc_pkg;

    localparam int FRAME_LEN_DEF = 9216;
    localparam int IN_WID_DEF    = 8;
    localparam int D_WID_DEF     = 6;
    localparam int PAR_DEF       = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    // Ceiling log2, floored at 1 so derived vectors never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ldpc_llr_buf_if.sv
// Decoder-facing read/release port of the LLR frame buffer.
interface ldpc_llr_buf_if
    import ldpc_pkg::*;
#(
    parameter int AW = clog2(FRAME_LEN_DEF / PAR_DEF),
    parameter int DW = PAR_DEF * D_WID_DEF
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          frame_rdy;
    logic          frame_done;

    modport master (output rd_en, rd_addr, frame_done, input rd_data, frame_rdy);
    modport slave  (input rd_en, rd_addr, frame_done, output rd_data, frame_rdy);
endinterface

// File: rtl/ldpc_llr_buf_sat.sv
// Symmetric clip of a signed soft value from IN_WID to D_WID bits; purely combinational.
module ldpc_llr_sat #(
    parameter int IN_WID = 8,
    parameter int D_WID  = 6
) (
    input  logic signed [IN_WID-1:0] din,
    output logic signed [D_WID-1:0]  dout
);
    localparam int                       MAXI = (1 << (D_WID - 1)) - 1;
    localparam logic signed [IN_WID-1:0] POS  = IN_WID'(MAXI);
    localparam logic signed [IN_WID-1:0] NEG  = -POS;

    always_comb begin
        dout = din[D_WID-1:0];
        if (din > POS) begin
            dout = POS[D_WID-1:0];
        end else if (din < NEG) begin
            dout = NEG[D_WID-1:0];
        end
    end
endmodule

// File: rtl/ldpc_llr_buf.sv
// Ping-pong LLR frame buffer in front of the LDPC decoder: clip, pack PAR samples/word, hand over full banks.
// Optional clipped-sample counter output sat_cnt is built when LDPC_LLR_SATCNT_EN is defined.
module ldpc_llr_buf
    import ldpc_pkg::*;
#(
    parameter int IN_WID    = IN_WID_DEF,
    parameter int D_WID     = D_WID_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int PAR       = PAR_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [IN_WID-1:0] data_in,
    input  logic                     sync_in,
    ldpc_llr_buf_if.slave            rd,
    output logic                     busy,
    output logic                     ovf,
    output logic                     short_err
`ifdef LDPC_LLR_SATCNT_EN
    ,
    output logic [clog2(FRAME_LEN+1)-1:0] sat_cnt
`endif
);
    localparam int WORDS = FRAME_LEN / PAR;
    localparam int AW    = clog2(WORDS);
    localparam int SW    = clog2(PAR);
    localparam int DW    = PAR * D_WID;

    wr_state_t state;
    logic [1:0]    full;
    logic          wr_ptr, rd_ptr, fill_bank;
    logic [SW-1:0] slot;
    logic [AW-1:0] waddr;

    logic signed [D_WID-1:0] sat_val;
    logic          pend, tgt_bank, cur_bank, accept, last_smp;

    logic          s1_vld, s1_last, s1_bank;
    logic [SW-1:0] s1_slot;
    logic [AW-1:0] s1_addr;
    logic [D_WID-1:0] s1_data;

    logic [DW-1:0] pack, next_word, s2_word;
    logic          s2_vld, s2_last, s2_bank;
    logic [AW-1:0] s2_addr;

    logic [DW-1:0] mem [0:2*WORDS-1];
    logic [AW:0]   wr_idx, rd_idx;

    ldpc_llr_sat #(.IN_WID(IN_WID), .D_WID(D_WID)) u_sat (
        .din  (data_in),
        .dout (sat_val)
    );

    // A finished frame still in the pipeline owns wr_ptr's bank, so a zero-gap
    // successor must already aim at the other bank.
    assign pend     = (s1_vld & s1_last) | (s2_vld & s2_last);
    assign tgt_bank = wr_ptr ^ pend;
    assign cur_bank = (state == W_IDLE) ? tgt_bank : fill_bank;
    assign accept   = sync_in && ((state == W_FILL) || ((state == W_IDLE) && !full[tgt_bank]));
    assign last_smp = (waddr == AW'(WORDS - 1)) && (slot == SW'(PAR - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= W_IDLE;
            slot      <= '0;
            waddr     <= '0;
            fill_bank <= 1'b0;
            ovf       <= 1'b0;
            short_err <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_bank   <= 1'b0;
            s1_slot   <= '0;
            s1_addr   <= '0;
            s1_data   <= '0;
        end else begin
            short_err <= 1'b0;
            s1_vld    <= accept;
            s1_last   <= accept & last_smp;
            if (accept) begin
                s1_bank <= cur_bank;
                s1_slot <= slot;
                s1_addr <= waddr;
                s1_data <= sat_val;
            end
            case (state)
                W_IDLE: begin
                    if (sync_in) begin
                        if (full[tgt_bank]) begin
                            state <= W_DROP;
                            ovf   <= 1'b1;
                        end else begin
                            fill_bank <= tgt_bank;
                            state     <= W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    if (!sync_in) begin
                        state     <= W_IDLE;
                        short_err <= 1'b1;
                    end
                end
                W_DROP: begin
                    if (!sync_in) state <= W_IDLE;
                end
                default: state <= W_IDLE;
            endcase
            if (accept) begin
                if (last_smp) begin
                    slot  <= '0;
                    waddr <= '0;
                    state <= W_IDLE;
                end else if (slot == SW'(PAR - 1)) begin
                    slot  <= '0;
                    waddr <= waddr + 1'b1;
                end else begin
                    slot <= slot + 1'b1;
                end
            end else if ((state == W_FILL) && !sync_in) begin
                slot  <= '0;
                waddr <= '0;
            end
        end
    end

    always_comb begin
        next_word = pack;
        for (int k = 0; k < PAR; k++) begin
            if (s1_slot == SW'(k)) next_word[k*D_WID +: D_WID] = s1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pack    <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_bank <= 1'b0;
            s2_addr <= '0;
            s2_word <= '0;
        end else begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            if (s1_vld) begin
                pack <= next_word;
                if (s1_slot == SW'(PAR - 1)) begin
                    s2_vld  <= 1'b1;
                    s2_last <= s1_last;
                    s2_bank <= s1_bank;
                    s2_addr <= s1_addr;
                    s2_word <= next_word;
                end
            end
        end
    end

    assign wr_idx = s2_bank ? ((AW+1)'(WORDS) + {1'b0, s2_addr}) : {1'b0, s2_addr};
    assign rd_idx = rd_ptr  ? ((AW+1)'(WORDS) + {1'b0, rd.rd_addr}) : {1'b0, rd.rd_addr};

    always_ff @(posedge clk) begin
        if (s2_vld) mem[wr_idx] <= s2_word;
    end

    // Commit and release never hit the same bank, so both bit updates may land together.
    always_ff @(posedge clk) begin
        if (reset) begin
            full       <= 2'b00;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            rd.rd_data <= '0;
        end else begin
            if (s2_vld && s2_last) begin
                full[s2_bank] <= 1'b1;
                wr_ptr        <= ~s2_bank;
            end
            if (rd.frame_done && full[rd_ptr]) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
            if (rd.rd_en && full[rd_ptr]) rd.rd_data <= mem[rd_idx];
        end
    end

    assign rd.frame_rdy = full[rd_ptr];
    assign busy         = full[wr_ptr];

`ifdef LDPC_LLR_SATCNT_EN
    localparam int SCW = clog2(FRAME_LEN + 1);
    logic           s1_clip;
    logic [SCW-1:0] clip_acc;

    // Running count restarts on each frame's first sample; published only on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_clip  <= 1'b0;
            clip_acc <= '0;
            sat_cnt  <= '0;
        end else begin
            if (accept) s1_clip <= (IN_WID'($signed(sat_val)) != data_in);
            if (s1_vld) begin
                clip_acc <= (((s1_slot == '0) && (s1_addr == '0)) ? '0 : clip_acc) + SCW'(s1_clip);
            end
            if (s2_vld && s2_last) sat_cnt <= clip_acc;
        end
    end
`endif

endmodule
